// File: rtl/instr_fetch_unit_if.sv
// Decoder/program-memory side of the fetch unit: PC strobes, IR strobes,
// program memory bus and the PC/IR/stack status seen by the decoder.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 13,
  parameter int INSTR_WIDTH = 14
);
  logic                   pc_incr_en;
  logic                   pc_j_en;
  logic                   pc_call_en;
  logic                   pc_ret_en;
  logic                   instr_rd_en;
  logic                   instr_flush;
  logic [1:0]             pclath_hi;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [PC_WIDTH-1:0]    prog_addr;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instr_current;
  logic                   stk_ovf;
  logic                   stk_unf;

  modport master (
    output pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, instr_rd_en, instr_flush,
           pclath_hi, prog_data,
    input  prog_addr, pc, instr_current, stk_ovf, stk_unf
  );

  modport slave (
    input  pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, instr_rd_en, instr_flush,
           pclath_hi, prog_data,
    output prog_addr, pc, instr_current, stk_ovf, stk_unf
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC, circular return stack and instruction register for the PIC16F-style core.
// Fetch overlaps execute: IR holds the word at PC-1 while PC addresses the next.
module instr_fetch_unit #(
  parameter int                     PC_WIDTH    = 13,
  parameter int                     INSTR_WIDTH = 14,
  parameter int                     STACK_DEPTH = 8,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.slave bus
);
  localparam int              SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0]   FULL = (SP_W+1)'(STACK_DEPTH);

  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    stack [STACK_DEPTH];
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [SP_W-1:0]        sp;
  logic [SP_W-1:0]        sp_dec;
  logic [SP_W:0]          depth;
  logic                   ovf;
  logic                   unf;
  logic                   push;
  logic                   pop;

  // Return outranks call, so a simultaneous call never pushes.
  assign pop    = bus.pc_ret_en;
  assign push   = bus.pc_call_en & ~bus.pc_ret_en;
  assign sp_dec = sp - SP_W'(1);
  assign target = {bus.pclath_hi, ir_q[PC_WIDTH-3:0]};

  // Stack RAM carries no reset; a push in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && push) stack[sp] <= pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ir_q  <= NOP_WORD;
      sp    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (pop)                 pc_q <= stack[sp_dec];
      else if (bus.pc_call_en) pc_q <= target;
      else if (bus.pc_j_en)    pc_q <= target;
      else if (bus.pc_incr_en) pc_q <= pc_q + PC_WIDTH'(1);

      if (pop) begin
        sp <= sp_dec;
        if (depth == '0) unf   <= 1'b1;
        else             depth <= depth - (SP_W+1)'(1);
      end else if (push) begin
        sp <= sp + SP_W'(1);
        if (depth == FULL) ovf   <= 1'b1;
        else               depth <= depth + (SP_W+1)'(1);
      end

      if (bus.instr_flush)      ir_q <= NOP_WORD;
      else if (bus.instr_rd_en) ir_q <= bus.prog_data;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.prog_addr     = pc_q;
  assign bus.instr_current = ir_q;
  assign bus.stk_ovf       = ovf;
  assign bus.stk_unf       = unf;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational program memory model.
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [13:0] mem [0:8191];

  instr_fetch_unit_if #(.PC_WIDTH(13), .INSTR_WIDTH(14)) bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.prog_data = mem[bus.prog_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.pc_ret_en   = 1'b0;
    bus.pc_call_en  = 1'b0;
    bus.pc_j_en     = 1'b0;
    bus.pc_incr_en  = 1'b0;
    bus.instr_rd_en = 1'b0;
    bus.instr_flush = 1'b0;
  endtask

  // One clock with the given strobes; outputs are stable #1 after the edge.
  task automatic cyc(input bit ret, input bit call, input bit j, input bit incr,
                     input bit rd, input bit flush);
    @(negedge clk);
    bus.pc_ret_en   = ret;
    bus.pc_call_en  = call;
    bus.pc_j_en     = j;
    bus.pc_incr_en  = incr;
    bus.instr_rd_en = rd;
    bus.instr_flush = flush;
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Place a goto-style word at the current PC, load it, then jump.
  task automatic goto_to(input logic [12:0] addr);
    mem[bus.pc] = {3'b000, addr[10:0]};
    cyc(0, 0, 0, 0, 1, 0);
    bus.pclath_hi = addr[12:11];
    cyc(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.pclath_hi = 2'b00;
    clr();
    for (int i = 0; i < 8192; i++) mem[i] = 14'h0000;

    // reset state
    do_reset();
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_addr", 32'(bus.prog_addr), 32'h0);
    chk("rst_ir", 32'(bus.instr_current), 32'h0);
    chk("rst_ovf", 32'(bus.stk_ovf), 32'h0);
    chk("rst_unf", 32'(bus.stk_unf), 32'h0);

    // sequential fetch
    mem[0] = 14'h3005;
    mem[1] = 14'h0000;
    mem[2] = 14'h2804;
    cyc(0, 0, 0, 1, 1, 0);
    chk("seq0_ir", 32'(bus.instr_current), 32'h3005);
    chk("seq0_pc", 32'(bus.pc), 32'h1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("seq1_ir", 32'(bus.instr_current), 32'h0000);
    chk("seq1_pc", 32'(bus.pc), 32'h2);
    cyc(0, 0, 0, 1, 1, 0);
    chk("seq2_ir", 32'(bus.instr_current), 32'h2804);
    chk("seq2_pc", 32'(bus.pc), 32'h3);

    // goto with PCLATH
    bus.pclath_hi = 2'b01;
    mem[13'h0804] = 14'h1234;
    cyc(0, 0, 1, 0, 0, 1);
    chk("goto_pc", 32'(bus.pc), 32'h0804);
    chk("goto_ir", 32'(bus.instr_current), 32'h0000);
    cyc(0, 0, 0, 1, 1, 0);
    chk("goto_fetch_ir", 32'(bus.instr_current), 32'h1234);
    chk("goto_fetch_pc", 32'(bus.pc), 32'h0805);

    // call / return
    goto_to(13'h0010);
    mem[13'h0010] = 14'h2020;
    cyc(0, 0, 0, 0, 1, 0);
    chk("cr_pre_pc", 32'(bus.pc), 32'h0010);
    chk("cr_pre_ir", 32'(bus.instr_current), 32'h2020);
    cyc(0, 1, 0, 0, 0, 0);
    chk("call_pc", 32'(bus.pc), 32'h0020);
    cyc(1, 0, 0, 0, 0, 0);
    chk("ret_pc", 32'(bus.pc), 32'h0010);
    chk("cr_ovf", 32'(bus.stk_ovf), 32'h0);
    chk("cr_unf", 32'(bus.stk_unf), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("cr_depth0_unf", 32'(bus.stk_unf), 32'h1);

    // overflow wrap: 9 pushes of 0x100+i, 8 pops, then underflow
    do_reset();
    goto_to(13'h0100);
    for (int i = 0; i < 9; i++) begin
      repeat (i) cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      if (i == 7) chk("ovf_full_not_yet", 32'(bus.stk_ovf), 32'h0);
    end
    chk("ovf_set", 32'(bus.stk_ovf), 32'h1);
    chk("ovf_unf", 32'(bus.stk_unf), 32'h0);
    for (int k = 8; k >= 1; k--) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk($sformatf("pop%0d_pc", k), 32'(bus.pc), 32'h100 + 32'(k));
    end
    chk("pop8_unf", 32'(bus.stk_unf), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("unf_set", 32'(bus.stk_unf), 32'h1);
    chk("unf_stale_pc", 32'(bus.pc), 32'h108);

    // priority: ret+call+incr only pops
    do_reset();
    goto_to(13'h0100);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    chk("prio_pc", 32'(bus.pc), 32'h102);
    cyc(1, 0, 0, 0, 0, 0);
    chk("prio_next_pc", 32'(bus.pc), 32'h101);
    chk("prio_unf0", 32'(bus.stk_unf), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("prio_unf1", 32'(bus.stk_unf), 32'h1);

    // flush beats read; PC wrap
    do_reset();
    cyc(0, 0, 0, 0, 1, 1);
    chk("flush_ir", 32'(bus.instr_current), 32'h0000);
    goto_to(13'h1FFF);
    chk("wrap_pre_pc", 32'(bus.pc), 32'h1FFF);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_pc", 32'(bus.pc), 32'h0000);
    bus.pclath_hi = 2'b00;

    // reset during call+rd drops the push
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    chk("mid_stale_pc", 32'(bus.pc), 32'h107);
    chk("mid_unf", 32'(bus.stk_unf), 32'h1);
    cyc(0, 0, 0, 1, 0, 0);
    mem[13'h0108] = 14'h3FFF;
    @(negedge clk);
    rst = 1'b1;
    bus.pc_call_en  = 1'b1;
    bus.instr_rd_en = 1'b1;
    bus.pc_incr_en  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    chk("mid_rst_pc", 32'(bus.pc), 32'h0);
    chk("mid_rst_ir", 32'(bus.instr_current), 32'h0);
    chk("mid_rst_unf", 32'(bus.stk_unf), 32'h0);
    chk("mid_rst_ovf", 32'(bus.stk_ovf), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mid_no_push_pc", 32'(bus.pc), 32'h107);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program counter, 8-level hardware return stack and instruction register for the PIC16F-style core.
- Sits directly upstream of the instruction decoder and produces instr_current for it.
- Consumes the decoder's per-Q-cycle strobes: pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, instr_rd_en and instr_flush.
- Addresses the program memory, which has a combinational read.
- Fetch and execute overlap: the IR holds the instruction at PC-1 while the PC points at the next word.

Parameters:
- PC_WIDTH, 13: program counter and program address width.
- INSTR_WIDTH, 14: instruction word width.
- STACK_DEPTH, 8: return stack entries; must be a power of two.
- NOP_WORD, 14'h0000: value loaded into the IR on reset and on flush.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc_incr_en  in  1  PC <= PC+1.
- pc_j_en  in  1  PC <= jump target (goto).
- pc_call_en  in  1  push PC, then PC <= jump target (call).
- pc_ret_en  in  1  PC <= popped stack entry (return/retlw/retfie).
- instr_rd_en  in  1  IR <= prog_data.
- instr_flush  in  1  IR <= NOP_WORD.
- pclath_hi  in  2  PCLATH<4:3>, upper bits of the jump target.
- prog_data  in  INSTR_WIDTH  program memory read data, valid in the same cycle as prog_addr.
- prog_addr  out  PC_WIDTH  program memory address; equals pc.
- pc  out  PC_WIDTH  current program counter.
- instr_current  out  INSTR_WIDTH  instruction register contents, fed to the decoder.
- stk_ovf  out  1  sticky: a push occurred with the stack full.
- stk_unf  out  1  sticky: a pop occurred with the stack empty.

Behaviour:
- Reset, synchronous, on any edge with rst=1:
  - pc=0, instr_current=NOP_WORD, sp=0, depth=0, stk_ovf=0, stk_unf=0.
  - Stack RAM contents are not reset.
  - rst overrides every strobe in the same cycle, including mid-instruction.
- All state updates on the clk rising edge. prog_addr = pc combinationally; no extra latency.
- Jump target = {pclath_hi, instr_current[10:0]}, computed from the IR value before the edge.
- PC update priority, highest first:
  - pc_ret_en: PC <= stack[sp-1].
  - pc_call_en: stack[sp] <= pc, PC <= target.
  - pc_j_en: PC <= target.
  - pc_incr_en: PC <= PC+1.
  - otherwise PC holds.
- Lower-priority PC strobes in the same cycle are ignored. Decoder misuse is not flagged.
- Call pushes the current pc. Because the decoder fetches before executing, this is the address of the instruction after the call.
- PC+1 wraps modulo 2^PC_WIDTH: 13'h1FFF -> 13'h0000.
- Stack is circular:
  - Push: write at sp, then sp <= sp+1 mod STACK_DEPTH.
  - Pop: sp <= sp-1 mod STACK_DEPTH, PC <= stack[sp-1].
- depth counter, 0..STACK_DEPTH:
  - Push with depth==STACK_DEPTH: oldest entry overwritten, depth stays at STACK_DEPTH, stk_ovf <= 1.
  - Pop with depth==0: PC still loads stack[sp-1] (stale data), sp still decrements, depth stays 0, stk_unf <= 1.
- IR update:
  - instr_flush: IR <= NOP_WORD; flush wins over instr_rd_en.
  - else instr_rd_en: IR <= prog_data, read from the pre-edge pc.
  - else IR holds.
- Sequencing under the decoder's four-cycle schedule:
  - Normal instruction at Q3 (rd+incr): IR <= mem[pc], pc+1.
  - goto at Q3 (flush+j): IR <= NOP, pc <= target. The next instruction slot executes the NOP and fetches mem[target] at its Q3, giving the two-cycle goto.
  - Skip taken (flush+incr): IR <= NOP and pc+1, so the instruction at pc is discarded.
- Simultaneous instr strobes and pc strobes are independent and both take effect on the same edge.

Test Plan:
- Reset, then 3 instructions' worth of decoder Q3 strobes (rd+incr) with mem[0..2]=14'h3005, 14'h0000, 14'h2804 -> instr_current successively 14'h3005, 14'h0000, 14'h2804; pc 1, 2, 3.
- IR=14'h2804 (goto 0x004), pclath_hi=2'b01, flush+j -> pc=13'h0804, instr_current=14'h0000. Next rd+incr -> instr_current=mem[0x0804], pc=13'h0805.
- Call-return: pc=13'h0010, IR=14'h2020, pc_call_en -> pc=13'h0020. Then pc_ret_en -> pc=13'h0010; depth back to 0; stk_ovf and stk_unf remain 0.
- Overflow wrap: 9 calls from distinct pcs A0..A8 -> stk_ovf=1. Then 8 returns -> pc sequence A8, A7 .. A1; the 9th return sets stk_unf=1.
- Priority and flush: ret+call+incr asserted together -> only the pop occurs, sp decrements once. rd+flush together -> instr_current=14'h0000. incr at pc=13'h1FFF -> pc=13'h0000.
- Reset mid-operation: assert rst during a cycle with call+rd active -> next cycle pc=0, instr_current=14'h0000, stk flags 0, and the push did not take effect.
